// File: rtl/mod_n_counter_pkg.sv
// Shared helpers for the modulo-N counter: count-width derivation.
package mod_n_counter_pkg;

  localparam int N_DEFAULT = 10;

  // Count width is ceil(log2(n)), never below one bit.
  function automatic int calc_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Count-enable / count / terminal-count bundle for one counter stage.
interface mod_n_counter_if #(
  parameter int W = 4
);
  logic         ce;
  logic [W-1:0] q;
  logic         ov;

  modport master (output ce, input q, input ov);
  modport slave  (input ce, output q, output ov);
endinterface

// File: rtl/mod_n_counter_core.sv
// Counter state and terminal-count decode, driven through the stage bundle.
module mod_n_counter_core
  import mod_n_counter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  mod_n_counter_if.slave  bus
);
  localparam int           W    = calc_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_q;
  logic         w_last;

  // >= also folds any out-of-range value back to 0 on the next enabled edge.
  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (bus.ce) begin
      if (r_q >= LAST) r_q <= '0;
      else             r_q <= r_q + 1'b1;
    end
  end

  assign w_last = (r_q == LAST);
  assign bus.q  = r_q;
  // Deliberately not gated by rst so a cascade sees a pure ce-qualified strobe.
  assign bus.ov = bus.ce & w_last;

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with clock enable and cascadable terminal-count output.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int W = calc_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  output logic [W-1:0] q,
  output logic         ov
);
  if (N < 2) begin : g_bad_n
    $fatal(1, "mod_n_counter: N must be >= 2");
  end

  mod_n_counter_if #(.W(W)) u_bus ();

  assign u_bus.ce = ce;
  assign q        = u_bus.q;
  assign ov       = u_bus.ov;

  mod_n_counter_core #(.N(N)) u_core (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

endmodule

// File: tb/tb_mod_n_counter.sv
// Checks a two-stage decade cascade (0..99) and an N=5 stage against a value model.
module tb_mod_n_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;
  int   v  = 0;   // cascaded pair value, 0..99
  int   c5 = 0;   // N=5 stage value

  always #5 clk = ~clk;

  mod_n_counter_if #(.W(4)) ifa ();
  mod_n_counter_if #(.W(4)) ifb ();
  mod_n_counter_if #(.W(3)) ifc ();

  assign ifb.ce = ifa.ce & ifa.ov;

  mod_n_counter #(.N(10)) u_a (.clk(clk), .rst(rst), .ce(ifa.ce), .q(ifa.q), .ov(ifa.ov));
  mod_n_counter #(.N(10)) u_b (.clk(clk), .rst(rst), .ce(ifb.ce), .q(ifb.q), .ov(ifb.ov));
  mod_n_counter #(.N(5))  u_c (.clk(clk), .rst(rst), .ce(ifc.ce), .q(ifc.q), .ov(ifc.ov));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got %0d exp %0d (v=%0d c5=%0d t=%0t)", tag, obs, exp, v, c5, $time);
    end
  endtask

  // One clock: drive at negedge, check strobes, then check counts after the edge.
  task automatic step(input logic r, input logic e, input logic e5);
    @(negedge clk);
    rst = r; ifa.ce = e; ifc.ce = e5;
    #1;
    chk("ov_a", {31'b0, ifa.ov}, {31'b0, e && (v % 10 == 9)});
    chk("ov_b", {31'b0, ifb.ov}, {31'b0, e && (v == 99)});
    chk("ov_c", {31'b0, ifc.ov}, {31'b0, e5 && (c5 == 4)});
    @(posedge clk);
    v  = r ? 0 : (e  ? (v + 1) % 100 : v);
    c5 = r ? 0 : (e5 ? (c5 + 1) % 5  : c5);
    #1;
    chk("q_a", 32'(ifa.q), 32'(v % 10));
    chk("q_b", 32'(ifb.q), 32'(v / 10));
    chk("q_c", 32'(ifc.q), 32'(c5));
  endtask

  initial begin
    ifa.ce = 1'b1; ifc.ce = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    v = 0; c5 = 0;
    step(1, 1, 1);

    repeat (25) step(0, 1, 1);

    // Hold at q_a = 4
    for (int i = 0; i < 10 && (v % 10 != 4); i++) step(0, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);

    // ce gates ov at q_a = 9
    for (int i = 0; i < 10 && (v % 10 != 9); i++) step(0, 1, 1);
    step(0, 0, 1);
    step(0, 1, 1);

    // Full cascade sweep 00..99 -> 00, then a pause
    step(1, 1, 1);
    repeat (100) step(0, 1, 0);
    chk("wrap_00", 32'(v), 32'd0);
    repeat (3) step(0, 0, 0);

    // Reset priority while N=5 stage sits at its terminal count
    for (int i = 0; i < 5 && (c5 != 4); i++) step(0, 0, 1);
    step(1, 1, 1);

    for (int i = 0; i < 400; i++)
      step(($urandom % 20) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
